// File: rtl/proc_pkg.sv
// Shared processor datapath constants and the holding-slot state type
// used by the write-side distributor.
package proc_pkg;

    localparam int WORD_W   = 24;
    localparam int NUM_DEST = 8;
    localparam int SEL_W    = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding slot: parks one word and presents it to its consumer
// until acknowledged; reports itself free when empty or being drained.
module demux_slot
    import proc_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] wdata,
    output logic             free,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_t      r_state;
    slot_state_t      w_state_next;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A write wins over an ack, so an acked slot can be refilled without a bubble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: if (wr) w_state_next = SLOT_FULL;
            SLOT_FULL:  if (ack && !wr) w_state_next = SLOT_EMPTY;
            default:    w_state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (wr) begin
            r_data <= wdata;
        end
    end

    assign valid = (r_state == SLOT_FULL);
    assign free  = (r_state == SLOT_EMPTY) || ack;
    assign data  = r_data;

endmodule

// File: rtl/demux8_slot_bank.sv
// Eight-way write-side distributor: routes one word per cycle (or a broadcast)
// into eight single-entry slots with per-destination backpressure.
module demux8_slot_bank
    import proc_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_CH = NUM_DEST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ack,
    output logic [15:0]             accept_cnt
);

    logic [NUM_CH-1:0] w_free;
    logic [NUM_CH-1:0] w_wr;
    logic              w_accept;
    logic [15:0]       r_accept_cnt;

    // Readiness never looks at in_valid, keeping the handshake loop-free.
    assign in_ready = in_bcast ? (&w_free) : w_free[in_sel];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_wr = '0;
        if (w_accept) begin
            if (in_bcast) begin
                w_wr = '1;
            end else begin
                w_wr[in_sel] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (w_wr[k]),
            .ack   (out_ack[k]),
            .wdata (in_data),
            .free  (w_free[k]),
            .valid (out_valid[k]),
            .data  (out_data[k*WIDTH +: WIDTH])
        );
    end

    // A broadcast counts as a single transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accept_cnt <= '0;
        end else if (w_accept) begin
            r_accept_cnt <= r_accept_cnt + 16'd1;
        end
    end

    assign accept_cnt = r_accept_cnt;

endmodule
